// File: rtl/load_data_align_pkg.sv
// Shared load/store encodings and helpers for the MEM/WB load path.
package load_data_align_pkg;

  localparam logic [2:0] LdLb  = 3'b000;
  localparam logic [2:0] LdLh  = 3'b001;
  localparam logic [2:0] LdLw  = 3'b010;
  localparam logic [2:0] LdLbu = 3'b011;
  localparam logic [2:0] LdLhu = 3'b100;
  localparam logic [2:0] StSb  = 3'b101;
  localparam logic [2:0] StSh  = 3'b110;
  localparam logic [2:0] StSw  = 3'b111;

  localparam int unsigned IoBit = 31;

  // Loads occupy the low five encodings; stores are the top three.
  function automatic logic is_load(logic [2:0] ctrl);
    return (ctrl <= LdLhu);
  endfunction

  function automatic logic is_misaligned(logic [2:0] ctrl, logic [1:0] off);
    logic mis;
    mis = 1'b0;
    unique case (ctrl)
      LdLh, LdLhu: mis = off[0];
      LdLw:        mis = (off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational big-endian byte/halfword/word select with sign or zero extension.
module load_extract
  import load_data_align_pkg::*;
(
  input  logic [2:0]  ctrl_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    unique case (off_i)
      2'd0: byte_sel = word_i[31:24];
      2'd1: byte_sel = word_i[23:16];
      2'd2: byte_sel = word_i[15:8];
      2'd3: byte_sel = word_i[7:0];
      default: byte_sel = 8'h00;
    endcase
    half_sel = off_i[1] ? word_i[15:0] : word_i[31:16];
  end

  always_comb begin
    data_o = 32'h0;
    unique case (ctrl_i)
      LdLb:    data_o = {{24{byte_sel[7]}}, byte_sel};
      LdLh:    data_o = {{16{half_sel[15]}}, half_sel};
      LdLw:    data_o = word_i;
      LdLbu:   data_o = {24'h0, byte_sel};
      LdLhu:   data_o = {16'h0, half_sel};
      default: data_o = 32'h0;
    endcase
  end

  assign misalign_o = is_misaligned(ctrl_i, off_i);

endmodule

// File: rtl/load_data_align.sv
// Writeback-side load alignment: captures MEM-stage load control, extracts and
// extends the returned word next cycle, and holds the result across stalls.
module load_data_align
  import load_data_align_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             mem_valid_i,
  input  logic [2:0]       ld_st_ctrl_i,
  input  logic [31:0]      alu_out_i,
  input  logic [31:0]      io_dout_i,
  input  logic [31:0]      dmem_dout_i,
  output logic [31:0]      ld_data_o,
  output logic             ld_valid_o,
  output logic             ld_misalign_o,
  output logic [CNT_W-1:0] misalign_cnt_o
);

  logic             s1_v_q;
  logic [2:0]       ctrl_q;
  logic [1:0]       off_q;
  logic             io_sel_q;
  logic [31:0]      io_q;

  logic             hold_v_q, hold_v_d;
  logic [31:0]      hold_data_q, hold_data_d;
  logic             hold_mis_q, hold_mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic [31:0]      live_src;
  logic [31:0]      live_data;
  logic             live_mis;
  logic             unused_addr;

  assign unused_addr = ^alu_out_i[30:2];
  assign accept      = mem_valid_i & is_load(ld_st_ctrl_i) & ~flush_i;
  assign live_src    = io_sel_q ? io_q : dmem_dout_i;

  load_extract u_extract (
    .ctrl_i     (ctrl_q),
    .off_i      (off_q),
    .word_i     (live_src),
    .data_o     (live_data),
    .misalign_o (live_mis)
  );

  // Snapshot the live result on the first stall edge; BRAM output drifts after that.
  always_comb begin
    hold_v_d    = hold_v_q;
    hold_data_d = hold_data_q;
    hold_mis_d  = hold_mis_q;
    if (flush_i || !stall_i) begin
      hold_v_d = 1'b0;
    end else if (s1_v_q && !hold_v_q) begin
      hold_v_d    = 1'b1;
      hold_data_d = live_data;
      hold_mis_d  = live_mis;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!stall_i && accept && is_misaligned(ld_st_ctrl_i, alu_out_i[1:0]) &&
        (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_v_q      <= 1'b0;
      ctrl_q      <= 3'b000;
      off_q       <= 2'b00;
      io_sel_q    <= 1'b0;
      io_q        <= 32'h0;
      hold_v_q    <= 1'b0;
      hold_data_q <= 32'h0;
      hold_mis_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (flush_i) begin
        s1_v_q <= 1'b0;
      end else if (!stall_i) begin
        s1_v_q   <= accept;
        ctrl_q   <= ld_st_ctrl_i;
        off_q    <= alu_out_i[1:0];
        io_sel_q <= alu_out_i[IoBit];
        io_q     <= io_dout_i;
      end
      hold_v_q    <= hold_v_d;
      hold_data_q <= hold_data_d;
      hold_mis_q  <= hold_mis_d;
      cnt_q       <= cnt_d;
    end
  end

  // Outputs are gated by valid so nothing stale leaks out after reset or flush.
  always_comb begin
    ld_valid_o    = s1_v_q;
    ld_data_o     = 32'h0;
    ld_misalign_o = 1'b0;
    if (s1_v_q) begin
      ld_data_o     = hold_v_q ? hold_data_q : live_data;
      ld_misalign_o = hold_v_q ? hold_mis_q : live_mis;
    end
  end

  assign misalign_cnt_o = cnt_q;

endmodule

// File: tb/tb_load_data_align.sv
// Self-checking bench for load_data_align: vector table, directed stall/flush/reset
// sequences and a randomized run against a behavioural model.
module tb_load_data_align;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        mem_valid = 1'b0;
  logic [2:0]  ctrl = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] io_dout = 32'h0;
  logic [31:0] dmem = 32'h0;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        ld_mis;
  logic [7:0]  cnt;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  load_data_align #(.CNT_W(8)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .stall_i        (stall),
    .flush_i        (flush),
    .mem_valid_i    (mem_valid),
    .ld_st_ctrl_i   (ctrl),
    .alu_out_i      (addr),
    .io_dout_i      (io_dout),
    .dmem_dout_i    (dmem),
    .ld_data_o      (ld_data),
    .ld_valid_o     (ld_valid),
    .ld_misalign_o  (ld_mis),
    .misalign_cnt_o (cnt)
  );

  // Behavioural model state
  logic        m_v = 0, m_held = 0, m_hmis = 0, m_io = 0;
  logic [2:0]  m_ctrl = 0;
  logic [1:0]  m_off = 0;
  logic [31:0] m_ioq = 0, m_hdata = 0;
  int          m_cnt = 0;

  function automatic logic [31:0] ref_ext(logic [2:0] c, logic [1:0] off, logic [31:0] w);
    int unsigned k, b, h;
    k = off;
    b = (w >> (24 - 8 * k)) & 32'hFF;
    h = (k >= 2) ? (w & 32'hFFFF) : (w >> 16);
    case (c)
      3'd0:    return (b >= 128) ? 32'(b + 32'hFFFF_FF00) : 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h + 32'hFFFF_0000) : 32'(h);
      3'd2:    return w;
      3'd3:    return 32'(b);
      3'd4:    return 32'(h);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_mis(logic [2:0] c, logic [1:0] off);
    int k;
    k = off;
    if (c == 3'd1 || c == 3'd4) return (k % 2) == 1;
    if (c == 3'd2) return k != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_src();
    return m_io ? m_ioq : dmem;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Advance the model with the pre-edge inputs, then take the clock edge.
  task automatic tick();
    if (!stall && !flush && mem_valid && ctrl <= 3'd4 && ref_mis(ctrl, addr[1:0]) &&
        m_cnt < 255) m_cnt++;
    if (flush) begin
      m_v = 0;
      m_held = 0;
    end else if (!stall) begin
      m_v = mem_valid && (ctrl <= 3'd4);
      m_ctrl = ctrl;
      m_off = addr[1:0];
      m_io = addr[31];
      m_ioq = io_dout;
      m_held = 0;
    end else if (m_v && !m_held) begin
      m_held = 1;
      m_hdata = ref_ext(m_ctrl, m_off, m_src());
      m_hmis = ref_mis(m_ctrl, m_off);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] ed;
    logic em;
    ed = 32'h0;
    em = 1'b0;
    if (m_v) begin
      ed = m_held ? m_hdata : ref_ext(m_ctrl, m_off, m_src());
      em = m_held ? m_hmis : ref_mis(m_ctrl, m_off);
    end
    chk({tag, ".valid"}, {31'h0, ld_valid}, {31'h0, m_v});
    chk({tag, ".data"}, ld_data, ed);
    chk({tag, ".mis"}, {31'h0, ld_mis}, {31'h0, em});
    chk({tag, ".cnt"}, {24'h0, cnt}, 32'(m_cnt));
  endtask

  task automatic model_reset();
    m_v = 0; m_held = 0; m_cnt = 0;
  endtask

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] word;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0] c0;
    vecs[0] = '{3'd0, 32'h0000_0001, 32'h12F3_5678, 32'hFFFF_FFF3, 1'b0};
    vecs[1] = '{3'd3, 32'h0000_0001, 32'h12F3_5678, 32'h0000_00F3, 1'b0};
    vecs[2] = '{3'd4, 32'h0000_0002, 32'h12F3_5678, 32'h0000_5678, 1'b0};
    vecs[3] = '{3'd1, 32'h0000_0000, 32'h1234_5678, 32'h0000_1234, 1'b0};
    vecs[4] = '{3'd2, 32'h0000_0002, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b1};
    vecs[5] = '{3'd2, 32'h8000_0004, 32'h0000_00A5, 32'h0000_00A5, 1'b0};
    vecs[6] = '{3'd1, 32'h0000_0012, 32'h0000_8001, 32'hFFFF_8001, 1'b0};
    vecs[7] = '{3'd4, 32'h0000_0003, 32'h1234_ABCD, 32'h0000_ABCD, 1'b1};
    vecs[8] = '{3'd0, 32'h0000_0003, 32'h0000_007F, 32'h0000_007F, 1'b0};
    vecs[9] = '{3'd2, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};

    #3;
    chk("reset.valid", {31'h0, ld_valid}, 32'h0);
    chk("reset.data", ld_data, 32'h0);
    chk("reset.mis", {31'h0, ld_mis}, 32'h0);
    chk("reset.cnt", {24'h0, cnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Vector table; I/O vectors present data on io_dout in MEM and then change it.
    foreach (vecs[i]) begin
      mem_valid = 1'b1;
      ctrl = vecs[i].ctrl;
      addr = vecs[i].addr;
      io_dout = vecs[i].addr[31] ? vecs[i].word : $urandom;
      dmem = $urandom;
      tick();
      mem_valid = 1'b0;
      dmem = vecs[i].addr[31] ? ~vecs[i].word : vecs[i].word;
      io_dout = $urandom;
      #1;
      chk($sformatf("vec%0d.valid", i), {31'h0, ld_valid}, 32'h1);
      chk($sformatf("vec%0d.data", i), ld_data, vecs[i].exp_data);
      chk($sformatf("vec%0d.mis", i), {31'h0, ld_mis}, {31'h0, vecs[i].exp_mis});
      chk($sformatf("vec%0d.cnt", i), {24'h0, cnt}, 32'(m_cnt));
    end
    tick();
    check_model("idle");

    // Misaligned LW bumps the counter once; stalled edges never count.
    c0 = cnt;
    mem_valid = 1'b1; ctrl = 3'd2; addr = 32'h2;
    tick();
    dmem = 32'hCAFE_BABE;
    #1;
    chk("mis_lw.cnt_inc", {24'h0, cnt}, {24'h0, c0 + 8'd1});
    chk("mis_lw.mis", {31'h0, ld_mis}, 32'h1);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mis_stall%0d.cnt", k), {24'h0, cnt}, {24'h0, c0 + 8'd1});
      chk($sformatf("mis_stall%0d.data", k), ld_data, 32'hCAFE_BABE);
    end
    stall = 1'b0; mem_valid = 1'b0;
    tick();
    check_model("mis_release");

    // Hold across a 4-cycle stall while the BRAM output changes underneath.
    mem_valid = 1'b1; ctrl = 3'd2; addr = 32'h0;
    tick();
    mem_valid = 1'b0; dmem = 32'h1357_9BDF; stall = 1'b1;
    #1;
    chk("hold.first", ld_data, 32'h1357_9BDF);
    for (int k = 0; k < 4; k++) begin
      tick();
      dmem = 32'h0;
      #1;
      chk($sformatf("hold%0d.valid", k), {31'h0, ld_valid}, 32'h1);
      chk($sformatf("hold%0d.data", k), ld_data, 32'h1357_9BDF);
    end
    stall = 1'b0;
    tick();
    chk("hold.drop", {31'h0, ld_valid}, 32'h0);
    check_model("hold_end");

    // Flush beats stall in the capture cycle.
    mem_valid = 1'b1; ctrl = 3'd0; addr = 32'h1;
    tick();
    stall = 1'b1; flush = 1'b1;
    tick();
    chk("flush.valid", {31'h0, ld_valid}, 32'h0);
    flush = 1'b0; stall = 1'b0; mem_valid = 1'b0;
    tick();
    check_model("flush_end");

    // Randomized traffic against the model.
    for (int k = 0; k < 300; k++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      mem_valid = ($urandom_range(0, 9) < 7);
      ctrl = 3'($urandom_range(0, 7));
      addr = {1'($urandom_range(0, 1)), 31'($urandom)};
      io_dout = $urandom;
      tick();
      dmem = $urandom;
      #1;
      check_model($sformatf("rnd%0d", k));
    end
    stall = 1'b0; flush = 1'b0;

    // Reset asserted mid-stall discards held data immediately.
    mem_valid = 1'b1; ctrl = 3'd2; addr = 32'h0;
    tick();
    mem_valid = 1'b0; dmem = 32'hA5A5_5A5A; stall = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid.valid", {31'h0, ld_valid}, 32'h0);
    chk("rst_mid.data", ld_data, 32'h0);
    chk("rst_mid.mis", {31'h0, ld_mis}, 32'h0);
    chk("rst_mid.cnt", {24'h0, cnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rel.valid", {31'h0, ld_valid}, 32'h0);
    chk("rst_rel.data", ld_data, 32'h0);
    stall = 1'b0;
    @(posedge clk);
    #1;

    // 300 misaligned loads saturate the counter.
    mem_valid = 1'b1; ctrl = 3'd2; addr = 32'h1;
    for (int k = 0; k < 300; k++) tick();
    chk("sat.cnt", {24'h0, cnt}, 32'd255);
    chk("sat.valid", {31'h0, ld_valid}, 32'h1);
    chk("sat.mis", {31'h0, ld_mis}, 32'h1);
    mem_valid = 1'b0;
    tick();
    check_model("sat_end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
